// File: rtl/traffic_pkg.sv
// Shared state encodings and lamp patterns for the actuated intersection controller.
package traffic_pkg;

  typedef enum logic [2:0] {
    A_GRN = 3'd0,
    A_YEL = 3'd1,
    B_GRN = 3'd2,
    B_YEL = 3'd3,
    WALK  = 3'd4,
    FLASH = 3'd5,
    MAINT = 3'd6
  } state_e;

  localparam logic [2:0] RED  = 3'b100;
  localparam logic [2:0] YEL  = 3'b010;
  localparam logic [2:0] GRN  = 3'b001;
  localparam logic [2:0] DARK = 3'b000;

  localparam logic [1:0] PED_STOP = 2'b10;
  localparam logic [1:0] PED_WALK = 2'b01;
  localparam logic [1:0] PED_OFF  = 2'b00;

endpackage

// File: rtl/phase_timer.sv
// Per-phase tick counter: flags expiry on the tick that completes `limit` ticks,
// optionally holding at the terminal count so a resting phase can leave on any later tick.
module phase_timer #(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          clr,
  input  logic [CW-1:0] limit,
  input  logic          sat,
  output logic          expired
);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] last_s;
  logic          at_last_s;

  assign last_s    = limit - CW'(1'b1);
  assign at_last_s = (cnt_r == last_s);
  assign expired   = tick && at_last_s;

  // Phase tick counter; clear has priority so every new phase starts from zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (clr) begin
      cnt_r <= {CW{1'b0}};
    end else if (tick) begin
      if (at_last_s) begin
        cnt_r <= sat ? cnt_r : {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + CW'(1'b1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Demand-driven phase sequencer: A rests green until side-road or pedestrian demand,
// with an all-red flashing maintenance override. Lamps are a Moore decode of state and blk.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int unsigned T_AGRN  = 4,
  parameter int unsigned T_AYEL  = 2,
  parameter int unsigned T_BGRN  = 3,
  parameter int unsigned T_BYEL  = 1,
  parameter int unsigned T_WALK  = 2,
  parameter int unsigned T_FLASH = 4,
  parameter int unsigned CW      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ped_req,
  input  logic       car_b,
  input  logic       maint,
  output logic [2:0] lightA,
  output logic [2:0] lightB,
  output logic [1:0] pedestrian,
  output logic [2:0] phase,
  output logic       ped_ack
);

  state_e        state_r;
  state_e        next_state_s;
  logic          car_pend_r;
  logic          ped_pend_r;
  logic          blk_r;
  logic          ped_ack_r;
  logic [CW-1:0] limit_s;
  logic          expired_s;
  logic          state_chg_s;
  logic          clr_s;
  logic          enter_b_s;
  logic          enter_walk_s;

  assign state_chg_s  = (next_state_s != state_r);
  // MAINT keeps the counter parked at zero so A_GRN gets its full minimum on exit
  assign clr_s        = state_chg_s || (state_r == MAINT);
  assign enter_b_s    = state_chg_s && (next_state_s == B_GRN);
  assign enter_walk_s = state_chg_s && (next_state_s == WALK);

  // Duration of the current phase in ticks
  always_comb begin
    limit_s = CW'(1'b1);
    case (state_r)
      A_GRN:   limit_s = CW'(T_AGRN);
      A_YEL:   limit_s = CW'(T_AYEL);
      B_GRN:   limit_s = CW'(T_BGRN);
      B_YEL:   limit_s = CW'(T_BYEL);
      WALK:    limit_s = CW'(T_WALK);
      FLASH:   limit_s = CW'(T_FLASH);
      default: limit_s = CW'(1'b1);
    endcase
  end

  phase_timer #(
    .CW(CW)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick),
    .clr    (clr_s),
    .limit  (limit_s),
    .sat    (state_r == A_GRN),
    .expired(expired_s)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= A_GRN;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state selection; maintenance overrides any expiry in the same cycle
  always_comb begin
    next_state_s = state_r;
    if (maint) begin
      next_state_s = MAINT;
    end else begin
      case (state_r)
        A_GRN: begin
          if (expired_s && (car_pend_r || ped_pend_r)) next_state_s = A_YEL;
          else                                          next_state_s = A_GRN;
        end
        A_YEL: begin
          if (!expired_s)     next_state_s = A_YEL;
          else if (car_pend_r) next_state_s = B_GRN;
          else                 next_state_s = WALK;
        end
        B_GRN: begin
          if (expired_s) next_state_s = B_YEL;
          else           next_state_s = B_GRN;
        end
        B_YEL: begin
          if (!expired_s)     next_state_s = B_YEL;
          else if (ped_pend_r) next_state_s = WALK;
          else                 next_state_s = A_GRN;
        end
        WALK: begin
          if (expired_s) next_state_s = FLASH;
          else           next_state_s = WALK;
        end
        FLASH: begin
          if (expired_s) next_state_s = A_GRN;
          else           next_state_s = FLASH;
        end
        MAINT:   next_state_s = A_GRN;
        default: next_state_s = A_GRN;
      endcase
    end
  end

  // Request latches (serving clear beats a same-cycle request), walk acknowledge, flash bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      car_pend_r <= 1'b0;
      ped_pend_r <= 1'b0;
      ped_ack_r  <= 1'b0;
      blk_r      <= 1'b0;
    end else begin
      if (enter_b_s)  car_pend_r <= 1'b0;
      else if (car_b) car_pend_r <= 1'b1;
      else            car_pend_r <= car_pend_r;

      if (enter_walk_s) ped_pend_r <= 1'b0;
      else if (ped_req) ped_pend_r <= 1'b1;
      else              ped_pend_r <= ped_pend_r;

      ped_ack_r <= enter_walk_s;

      if (state_chg_s)                                       blk_r <= 1'b0;
      else if (tick && (state_r == FLASH || state_r == MAINT)) blk_r <= ~blk_r;
      else                                                   blk_r <= blk_r;
    end
  end

  // Lamp decode from registered state and flash bit
  always_comb begin
    lightA     = GRN;
    lightB     = RED;
    pedestrian = PED_STOP;
    case (state_r)
      A_GRN: begin lightA = GRN; lightB = RED; pedestrian = PED_STOP; end
      A_YEL: begin lightA = YEL; lightB = RED; pedestrian = PED_STOP; end
      B_GRN: begin lightA = RED; lightB = GRN; pedestrian = PED_STOP; end
      B_YEL: begin lightA = RED; lightB = YEL; pedestrian = PED_STOP; end
      WALK:  begin lightA = RED; lightB = RED; pedestrian = PED_WALK; end
      FLASH: begin
        lightA     = RED;
        lightB     = RED;
        pedestrian = blk_r ? PED_OFF : PED_STOP;
      end
      MAINT: begin
        if (blk_r) begin
          lightA = DARK; lightB = DARK; pedestrian = PED_OFF;
        end else begin
          lightA = RED;  lightB = RED;  pedestrian = PED_STOP;
        end
      end
      default: begin lightA = RED; lightB = RED; pedestrian = PED_STOP; end
    endcase
  end

  assign phase   = state_r;
  assign ped_ack = ped_ack_r;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench: a countdown-based reference model predicts the lamps each cycle,
// a monitor compares them against the scheduler one edge later.
module tb_traffic_phase_scheduler;

  typedef struct packed {
    logic [2:0] la;
    logic [2:0] lb;
    logic [1:0] pd;
    logic [2:0] ph;
    logic       ack;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       ped_req = 1'b0;
  logic       car_b = 1'b0;
  logic       maint = 1'b0;
  logic [2:0] lightA;
  logic [2:0] lightB;
  logic [1:0] pedestrian;
  logic [2:0] phase;
  logic       ped_ack;

  obs_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // reference model: phase number, ticks still to run, latches, flash bit
  int   m_phase;
  int   m_left;
  bit   m_car, m_ped, m_blk, m_ack;
  int   dur[6] = '{4, 2, 3, 1, 2, 4};

  traffic_phase_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .ped_req   (ped_req),
    .car_b     (car_b),
    .maint     (maint),
    .lightA    (lightA),
    .lightB    (lightB),
    .pedestrian(pedestrian),
    .phase     (phase),
    .ped_ack   (ped_ack)
  );

  always #5 clk = ~clk;

  function automatic obs_t expect_of(int ph, bit b, bit ack);
    obs_t o;
    o.ph  = 3'(ph);
    o.ack = ack;
    case (ph)
      0: begin o.la = 3'b001; o.lb = 3'b100; o.pd = 2'b10; end
      1: begin o.la = 3'b010; o.lb = 3'b100; o.pd = 2'b10; end
      2: begin o.la = 3'b100; o.lb = 3'b001; o.pd = 2'b10; end
      3: begin o.la = 3'b100; o.lb = 3'b010; o.pd = 2'b10; end
      4: begin o.la = 3'b100; o.lb = 3'b100; o.pd = 2'b01; end
      5: begin o.la = 3'b100; o.lb = 3'b100; o.pd = b ? 2'b00 : 2'b10; end
      default: begin
        o.la = b ? 3'b000 : 3'b100;
        o.lb = b ? 3'b000 : 3'b100;
        o.pd = b ? 2'b00 : 2'b10;
      end
    endcase
    return o;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_left = dur[0];
    m_car = 1'b0; m_ped = 1'b0; m_blk = 1'b0; m_ack = 1'b0;
  endtask

  task automatic model_step(input bit c, input bit p, input bit m, input bit t);
    int np;
    bit changed;
    if (!rst) begin
      model_reset();
    end else begin
      if (m) np = 6;
      else if (m_phase == 6) np = 0;
      else if (t && m_left == 1) begin
        case (m_phase)
          0: np = (m_car || m_ped) ? 1 : 0;
          1: np = m_car ? 2 : 4;
          2: np = 3;
          3: np = m_ped ? 4 : 0;
          4: np = 5;
          default: np = 0;
        endcase
      end else np = m_phase;
      changed = (np != m_phase);
      m_car = (changed && np == 2) ? 1'b0 : (m_car | c);
      m_ped = (changed && np == 4) ? 1'b0 : (m_ped | p);
      m_ack = changed && (np == 4);
      if (changed) m_blk = 1'b0;
      else if (t && m_phase >= 5) m_blk = ~m_blk;
      if (np == 6) m_left = 0;
      else if (changed) m_left = dur[np];
      else if (t && m_left > 1) m_left = m_left - 1;
      m_phase = np;
    end
  endtask

  // one clock of stimulus; expected post-edge outputs go to the scoreboard
  task automatic cyc(input bit c, input bit p, input bit m, input bit t);
    @(negedge clk);
    car_b = c; ped_req = p; maint = m; tick = t;
    model_step(c, p, m, t);
    exp_q.push_back(expect_of(m_phase, m_blk, m_ack));
  endtask

  task automatic run_ticks(input int n, input bit c, input bit p, input bit m);
    for (int i = 0; i < n * 4; i++) cyc(c, p, m, (i % 4) == 3);
  endtask

  task automatic check_now(input string name);
    obs_t g, e;
    g = {lightA, lightB, pedestrian, phase, ped_ack};
    e = expect_of(0, 1'b0, 1'b0);
    vectors++;
    if (g !== e) begin
      miscompares++;
      $display("FAIL %s: got A=%b B=%b P=%b ph=%0d ack=%b, required A=%b B=%b P=%b ph=%0d ack=%b",
               name, g.la, g.lb, g.pd, g.ph, g.ack, e.la, e.lb, e.pd, e.ph, e.ack);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b0; tick = 1'b0; car_b = 1'b0; ped_req = 1'b0; maint = 1'b0;
    #1 check_now("async_reset");
    model_reset();
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
  endtask

  // monitor: outputs are valid every cycle, compare just after each active edge
  initial begin
    obs_t e, g;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {lightA, lightB, pedestrian, phase, ped_ack};
        vectors++;
        if (g !== e) begin
          miscompares++;
          $display("FAIL lamps t=%0t: got A=%b B=%b P=%b ph=%0d ack=%b, required A=%b B=%b P=%b ph=%0d ack=%b",
                   $time, g.la, g.lb, g.pd, g.ph, g.ack, e.la, e.lb, e.pd, e.ph, e.ack);
        end
      end
    end
  end

  initial begin
    bit t, p, c, mnt;
    model_reset();
    #1 rst = 1'b0;
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check_now("reset_hold");
    rst = 1'b1;

    // idle: rests in A_GRN
    run_ticks(20, 1'b0, 1'b0, 1'b0);
    // single pedestrian press
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    run_ticks(12, 1'b0, 1'b0, 1'b0);

    // both requests held from reset: full rotation
    do_reset();
    run_ticks(18, 1'b1, 1'b1, 1'b0);

    // press coincident with WALK entry counts as served
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 48; i++) begin
      t = (i % 4) == 3;
      p = t && m_phase == 1 && m_left == 1;
      cyc(1'b0, p, 1'b0, t);
    end
    run_ticks(6, 1'b0, 1'b0, 1'b0);

    // maintenance from mid B_GRN, request latched while in MAINT
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 64 && m_phase != 2; i++) cyc(1'b0, 1'b0, 1'b0, (i % 4) == 3);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    run_ticks(5, 1'b0, 1'b0, 1'b1);
    run_ticks(8, 1'b0, 1'b0, 1'b0);

    // reset during WALK with a car pending
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 64 && m_phase != 4; i++) cyc(1'b0, 1'b0, 1'b0, (i % 4) == 3);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    do_reset();
    run_ticks(8, 1'b0, 1'b0, 1'b0);

    // randomized traffic
    mnt = 1'b0;
    for (int i = 0; i < 800; i++) begin
      t = ($urandom_range(0, 2) == 0);
      c = ($urandom_range(0, 15) == 0);
      p = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 59) == 0) mnt = ~mnt;
      cyc(c, p, mnt, t);
    end

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/traffic_phase_scheduler.md
# traffic_phase_scheduler

Demand-driven phase scheduler for the two-road intersection with one pedestrian crossing. It replaces the fixed 16 s rotation with actuated sequencing. Main road A rests in green until a side-road vehicle or a pedestrian is waiting. Each phase runs for a parameterised number of 1 s ticks, and a maintenance mode gives all-red flashing. It sits after the 1 Hz tick divider and drives the lamp outputs directly.

## Interface
- `T_AGRN`, default 4: minimum A-green time, in ticks.
- `T_AYEL`, default 2: A-yellow time, in ticks.
- `T_BGRN`, default 3: B-green time, in ticks.
- `T_BYEL`, default 1: B-yellow time, in ticks.
- `T_WALK`, default 2: pedestrian walk time, in ticks.
- `T_FLASH`, default 4: pedestrian flash time, in ticks.
- `CW`, default 4: width of the phase counter. Every `T_*` value must be ≥1 and ≤2^CW−1.
- `clk`, in, 1: system clock. This is the only clock.
- `rst`, in, 1: asynchronous, active-low reset.
- `tick`, in, 1: one-`clk`-wide pulse once per second.
- `ped_req`, in, 1: pedestrian button, level. Sampled every `clk`.
- `car_b`, in, 1: road-B vehicle detector, level. Sampled every `clk`.
- `maint`, in, 1: maintenance request, level.
- `lightA`, out, 3: road A lamps, one-hot. 100 = red, 010 = yellow, 001 = green, 000 = dark.
- `lightB`, out, 3: road B lamps, same encoding as `lightA`.
- `pedestrian`, out, 2: crossing lamps. 10 = don't walk, 01 = walk, 00 = dark.
- `phase`, out, 3: current state encoding, for debug and display.
- `ped_ack`, out, 1: one-cycle pulse when WALK is entered.

## Operation
- States and their encodings: A_GRN=0, A_YEL=1, B_GRN=2, B_YEL=3, WALK=4, FLASH=5, MAINT=6.
- Lamps per state, given as lightA / lightB / pedestrian:
  - A_GRN: 001 / 100 / 10
  - A_YEL: 010 / 100 / 10
  - B_GRN: 100 / 001 / 10
  - B_YEL: 100 / 010 / 10
  - WALK: 100 / 100 / 01
  - FLASH: 100 / 100, with pedestrian alternating 10 and 00
  - MAINT: alternating between all-red (100 / 100 / 10) and all-dark (000 / 000 / 00)
- Phase counter `cnt`:
  - Increments only on `tick`.
  - A state "expires" on a `tick` when `cnt == T_state−1`.
  - On any state change, `cnt` clears to 0.
- Pending latches:
  - `car_pend` is set by `car_b` and cleared on entry to B_GRN.
  - `ped_pend` is set by `ped_req` and cleared on entry to WALK.
  - If set and clear occur in the same cycle, clear wins: the request counts as served.
- Transitions:
  - A_GRN → A_YEL when expired and (`car_pend` | `ped_pend`). Otherwise it stays, and `cnt` saturates at `T_AGRN−1`, so it leaves on the first `tick` after a request arrives.
  - A_YEL → B_GRN if `car_pend`, else → WALK. This happens on expiry.
  - B_GRN → B_YEL on expiry.
  - B_YEL → WALK if `ped_pend`, else → A_GRN. This happens on expiry.
  - WALK → FLASH on expiry.
  - FLASH → A_GRN on expiry.
- Flash bit `blk`:
  - Clears on entry to FLASH or MAINT.
  - Toggles on every `tick` while in FLASH or MAINT.
  - `blk=0` selects the lit pattern; `blk=1` selects the dark pattern.
- Maintenance:
  - `maint=1` on any `clk` edge forces MAINT from any state. `cnt` and `blk` clear; the pending latches are kept.
  - While in MAINT, the pending latches still collect requests.
  - On the first `clk` edge with `maint=0` in MAINT, the block goes to A_GRN with `cnt=0`.

## Timing
- Reset state (during and after reset): A_GRN, `cnt=0`, `blk=0`, both pending latches 0. Outputs are `lightA=001`, `lightB=100`, `pedestrian=10`, `phase=0`, `ped_ack=0`.
- Lamps and `phase` are a Moore decode of the registered state and `blk`. They change on the same `clk` edge that samples the expiring `tick`, with 0-cycle added latency.
- `ped_ack` is registered and is high in the first cycle of WALK.
- Minimum A_GRN dwell is exactly `T_AGRN` ticks after entry, including when entry comes from reset or from MAINT.
- A `tick` in the same cycle as `maint=1`: `maint` wins; no expiry is processed.
- An asynchronous reset mid-phase returns the block to the reset state immediately. Deassertion is synchronised by the integrator.

## Structure
- Shared `traffic_pkg`:
  - state encodings
  - lamp constants `RED=3'b100`, `YEL=3'b010`, `GRN=3'b001`, `DARK=3'b000`, `PED_STOP=2'b10`, `PED_WALK=2'b01`, `PED_OFF=2'b00`
- One sub-module `phase_timer`:
  - ports `clk`, `rst`, `tick`, `clr`, `limit[CW-1:0]`, `sat`
  - output `expired`
  - holds `cnt`
- The FSM, pending latches and lamp decode live in `traffic_phase_scheduler`.

## Test plan
- Release reset with no requests and apply 20 ticks → stays in A_GRN throughout; outputs 001 / 100 / 10.
- Pulse `ped_req` once in A_GRN after 10 ticks → A_YEL on the next tick for 2 ticks, then WALK: `ped_ack` pulses, `pedestrian=01` for 2 ticks. Then FLASH for 4 ticks with `pedestrian` sequence 10, 00, 10, 00, then A_GRN.
- Hold `car_b` and `ped_req` from reset → A_GRN 4 ticks, A_YEL 2, B_GRN 3, B_YEL 1, WALK 2, FLASH 4, back to A_GRN. `phase` sequence is 0, 1, 2, 3, 4, 5, 0.
- Pulse `ped_req` in the same cycle WALK is entered → `ped_pend` ends at 0; after FLASH the block rests in A_GRN.
- Assert `maint` in B_GRN mid-phase → MAINT on the next `clk`. Lamps alternate 100 / 100 / 10 and 000 / 000 / 00 each tick. Deassert `maint` → A_GRN with a full 4-tick minimum; a `car_pend` latched earlier leads to A_YEL after that.
- Assert `rst` low during WALK → immediately 001 / 100 / 10, `phase=0`, and both pending latches cleared.
